addsub_serial: RTL



---
 rtl/addsub_serial.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/addsub_serial.sv
// addsub_serial - digit-serial signed adder/subtractor with start/done handshake.
//
// A single D-bit adder slice is reused across cycles. Both operands are
// sign-extended to NDIG*D bits and consumed LSB-digit first. The result is
// assembled in a shift register, and its low W+1 bits are loaded into z on
// the edge that enters DONE. The result is the exact (W+1)-bit value of x+y
// or x-y.
//
// Optional build macro: ADDSUB_SERIAL_FLAGS_EN adds the registered result
// flags zero and neg.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   operation request, sampled only in IDLE
//   sub    in   0: x+y, 1: x-y (sampled with start)
//   x, y   in   W-bit signed operands (sampled with start)
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse, z valid
//   z      out  W+1-bit signed result, held until next completion or reset
//   zero   out  (flags build) result is all zeros
//   neg    out  (flags build) sign bit of the result
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start, operands latched on start
// RUN   | one D-bit digit added per edge, NDIG edges in total
// DONE  | result in z, done pulses for one cycle, back to IDLE

module addsub_serial #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
`ifdef ADDSUB_SERIAL_FLAGS_EN
  output logic [W:0]   z,
  output logic         zero,
  output logic         neg
`else
  output logic [W:0]   z
`endif
);

  localparam int NDIG = (W + 1 + D - 1) / D;
  localparam int PW   = NDIG * D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0] a_sr;
  logic [PW-1:0] b_sr;
  logic [PW-1:0] res_sr;
  logic          carry;
  logic [CW-1:0] cnt;

  logic [D:0]    sum;
  logic [PW-1:0] sum_ext;
  logic [PW-1:0] res_nxt;
  logic          last_digit;
  logic          load;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_digit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Digit slice: the carry-out of the top digit of the padded word is dropped.
  always_comb begin
    sum        = {1'b0, a_sr[D-1:0]} + {1'b0, b_sr[D-1:0]} + {{D{1'b0}}, carry};
    sum_ext    = PW'(sum[D-1:0]);
    // New digit enters at the top so the first digit ends up at bit 0.
    res_nxt    = (res_sr >> D) | (sum_ext << (PW - D));
    last_digit = (cnt == CW'(NDIG - 1));
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      z      <= '0;
`ifdef ADDSUB_SERIAL_FLAGS_EN
      zero   <= 1'b0;
      neg    <= 1'b0;
`endif
    end else if (load) begin
      a_sr  <= {{(PW - W){x[W-1]}}, x};
      // Subtraction as A + ~B + 1: invert B here, the +1 is the initial carry.
      b_sr  <= {{(PW - W){y[W-1]}}, y} ^ {PW{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> D;
      b_sr   <= b_sr >> D;
      carry  <= sum[D];
      res_sr <= res_nxt;
      cnt    <= cnt + CW'(1);
      if (last_digit) begin
        z    <= res_nxt[W:0];
`ifdef ADDSUB_SERIAL_FLAGS_EN
        zero <= (res_nxt[W:0] == '0);
        neg  <= res_nxt[W];
`endif
      end
    end
  end

endmodule
